// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable integer clock divider.
//
// Divides i_ref_clk by a programmable integer ratio N (0..2^WIDTH-1).
// A divided period is exactly N reference cycles. The output is high for
// floor(N/2) cycles, or for exactly N/2 cycles on odd N when ODD_DUTY_50=1
// (a falling-edge flop adds half a cycle to the high phase). New ratios and
// enable changes take effect only in IDLE or at a period boundary, so the
// output never glitches. Ratio 1 bypasses the reference clock straight
// through. Ratio 0 holds the output low.
//
// Ports:
//   i_ref_clk   reference clock (rising edge; falling edge for odd-duty flop)
//   i_rst       asynchronous active-high reset
//   i_clk_en    divider enable, sampled in IDLE or at a period boundary
//   i_div_ratio requested ratio N, sampled in IDLE or at a period boundary
//   o_div_clk   divided clock
//   o_tick      high for the last reference cycle of each divided period
//   o_active    high while the divider is running
module clk_div_prog #(
    parameter int WIDTH       = 8,
    parameter bit ODD_DUTY_50 = 1'b0
) (
    input  logic             i_ref_clk,
    input  logic             i_rst,
    input  logic             i_clk_en,
    input  logic [WIDTH-1:0] i_div_ratio,
    output logic             o_div_clk,
    output logic             o_tick,
    output logic             o_active
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] RATIO_ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ratio_q, ratio_d;
    logic             q_pos_q, q_pos_d;
    logic             byp_q, byp_d;

    logic [WIDTH-1:0] half;
    logic [WIDTH:0]   cnt_inc;
    logic             at_boundary;
    logic             start_ok;
    logic             odd_ext;

    assign half = ratio_q >> 1;

    // One extra bit so cnt+1 cannot wrap when ratio_q is at its maximum.
    assign cnt_inc     = {1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1};
    assign at_boundary = (state_q == ST_RUN) && (cnt_inc == {1'b0, ratio_q});
    assign start_ok    = i_clk_en && (i_div_ratio > RATIO_ONE);

    // State register
    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ratio_q <= '0;
            q_pos_q <= 1'b0;
            byp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            q_pos_q <= q_pos_d;
            byp_q   <= byp_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        q_pos_d = q_pos_q;
        byp_d   = byp_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                q_pos_d = 1'b0;
                byp_d   = i_clk_en && (i_div_ratio == RATIO_ONE);
                if (start_ok) begin
                    ratio_d = i_div_ratio;
                    q_pos_d = 1'b1;
                    byp_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!at_boundary) begin
                    cnt_d   = cnt_inc[WIDTH-1:0];
                    q_pos_d = (cnt_inc < {1'b0, half});
                end else begin
                    // Period boundary: the only place inputs are resampled.
                    cnt_d = '0;
                    if (start_ok) begin
                        ratio_d = i_div_ratio;
                        q_pos_d = 1'b1;
                    end else begin
                        q_pos_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Odd-ratio half-cycle extension of the high phase.
    generate
        if (ODD_DUTY_50) begin : g_odd_duty
            logic q_neg_q;
            logic q_neg_d;

            assign q_neg_d = q_pos_q;

            always_ff @(negedge i_ref_clk or posedge i_rst) begin
                if (i_rst) begin
                    q_neg_q <= 1'b0;
                end else begin
                    q_neg_q <= q_neg_d;
                end
            end

            assign odd_ext = q_neg_q & ratio_q[0] & (state_q == ST_RUN);
        end else begin : g_floor_duty
            assign odd_ext = 1'b0;
        end
    endgenerate

    // Outputs. byp_q only changes in IDLE while the divided output is low,
    // so switching the mux onto the reference clock cannot glitch.
    always_comb begin
        o_active = (state_q == ST_RUN);
        o_tick   = at_boundary;
        if ((state_q == ST_IDLE) && byp_q) begin
            o_div_clk = i_ref_clk;
        end else begin
            o_div_clk = q_pos_q | odd_ext;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Testbench for clk_div_prog: two instances (floor duty and exact 50% duty)
// share one stimulus stream and are compared against a period/phase model.
module tb_clk_div_prog;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] ratio;

    logic div0, tick0, act0;
    logic div1, tick1, act1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: running flag, period length and position in period.
    bit m_run;
    bit m_byp;
    int m_n;
    int m_k;

    clk_div_prog #(.WIDTH(W), .ODD_DUTY_50(1'b0)) u_dut_floor (
        .i_ref_clk   (clk),
        .i_rst       (rst),
        .i_clk_en    (en),
        .i_div_ratio (ratio),
        .o_div_clk   (div0),
        .o_tick      (tick0),
        .o_active    (act0)
    );

    clk_div_prog #(.WIDTH(W), .ODD_DUTY_50(1'b1)) u_dut_half (
        .i_ref_clk   (clk),
        .i_rst       (rst),
        .i_clk_en    (en),
        .i_div_ratio (ratio),
        .o_div_clk   (div1),
        .o_tick      (tick1),
        .o_active    (act1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_run = 1'b0;
        m_byp = 1'b0;
        m_n   = 0;
        m_k   = 0;
    endfunction

    // One rising edge of the reference clock in terms of divided periods.
    function automatic void model_edge();
        int r;
        r = int'(ratio);
        if (!m_run) begin
            m_byp = en && (r == 1);
            if (en && r >= 2) begin
                m_run = 1'b1;
                m_n   = r;
                m_k   = 0;
            end
        end else if (m_k == m_n - 1) begin
            m_k = 0;
            if (en && r >= 2) m_n = r;
            else m_run = 1'b0;
        end else begin
            m_k++;
        end
    endfunction

    // Expected divided clock in the given half of the current reference cycle.
    // Exact-duty mode: high for the first N half-cycles of the period.
    // Floor mode: high for the first floor(N/2) whole cycles.
    function automatic bit exp_div(input bit half_mode, input bit neg_half);
        if (!m_run) return m_byp ? !neg_half : 1'b0;
        if (half_mode) return (2 * m_k + int'(neg_half)) < m_n;
        return m_k < (m_n / 2);
    endfunction

    function automatic bit exp_tick();
        return m_run && (m_k == m_n - 1);
    endfunction

    task automatic cycle(input bit e, input logic [W-1:0] r);
        en    = e;
        ratio = r;
        @(posedge clk);
        model_edge();
        #1;
        check("div_floor_pos", 32'(div0), 32'(exp_div(1'b0, 1'b0)));
        check("div_half_pos", 32'(div1), 32'(exp_div(1'b1, 1'b0)));
        check("tick_floor", 32'(tick0), 32'(exp_tick()));
        check("tick_half", 32'(tick1), 32'(exp_tick()));
        check("active_floor", 32'(act0), 32'(m_run));
        check("active_half", 32'(act1), 32'(m_run));
        @(negedge clk);
        #1;
        check("div_floor_neg", 32'(div0), 32'(exp_div(1'b0, 1'b1)));
        check("div_half_neg", 32'(div1), 32'(exp_div(1'b1, 1'b1)));
    endtask

    // Advance with fixed inputs until the model sits at position k of a
    // period of length n; an exhausted budget counts as a failure.
    task automatic run_until(input bit e, input logic [W-1:0] r, input int n, input int k);
        int guard;
        guard = 0;
        while (!(m_run && m_n == n && m_k == k) && guard < 600) begin
            cycle(e, r);
            guard++;
        end
        check("wait_budget", 32'(guard < 600), 32'd1);
    endtask

    // Asynchronous reset pulse shortly after a rising edge.
    task automatic reset_mid();
        @(posedge clk);
        model_edge();
        #2;
        check("pre_rst_div_floor", 32'(div0), 32'(exp_div(1'b0, 1'b0)));
        check("pre_rst_div_half", 32'(div1), 32'(exp_div(1'b1, 1'b0)));
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_div_floor", 32'(div0), 32'd0);
        check("rst_div_half", 32'(div1), 32'd0);
        check("rst_tick", 32'({tick0, tick1}), 32'd0);
        check("rst_active", 32'({act0, act1}), 32'd0);
        @(negedge clk);
        #1;
        check("rst_hold_div", 32'({div0, div1}), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rr;
        bit           ee;
        int           len;
        int           sel;

        rst   = 1'b0;
        en    = 1'b0;
        ratio = '0;
        model_reset();
        #1;
        rst = 1'b1;
        #2;
        check("reset_div", 32'({div0, div1}), 32'd0);
        check("reset_tick", 32'({tick0, tick1}), 32'd0);
        check("reset_active", 32'({act0, act1}), 32'd0);
        @(posedge clk);
        #1;
        check("reset_hold", 32'({div0, div1, act0, act1}), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Even ratio, then odd ratio.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'd4);
        for (int i = 0; i < 15; i++) cycle(1'b1, 8'd5);
        for (int i = 0; i < 9; i++) cycle(1'b1, 8'd3);

        // Ratio 4 -> 6 requested at position 1 of a period.
        run_until(1'b1, 8'd4, 4, 1);
        for (int i = 0; i < 18; i++) cycle(1'b1, 8'd6);

        // Disable at position 1 of a ratio-6 period.
        run_until(1'b1, 8'd6, 6, 1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'd6);

        // Bypass, then ratio 0, then leave bypass into a run.
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'd1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'd0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'd1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'd7);

        // Reset in the high phase, then restart.
        run_until(1'b1, 8'd8, 8, 0);
        reset_mid();
        for (int i = 0; i < 12; i++) cycle(1'b1, 8'd8);

        // Maximum ratio.
        for (int i = 0; i < 520; i++) cycle(1'b1, 8'd255);
        for (int i = 0; i < 300; i++) cycle(1'b0, 8'd255);

        // Randomised segments with mid-period changes.
        for (int s = 0; s < 120; s++) begin
            sel = int'($urandom_range(0, 11));
            case (sel)
                0:       rr = 8'd0;
                1:       rr = 8'd1;
                2:       rr = 8'd255;
                3:       rr = 8'd254;
                default: rr = 8'($urandom_range(2, 12));
            endcase
            ee  = ($urandom_range(0, 5) != 0);
            len = int'($urandom_range(1, 30));
            for (int i = 0; i < len; i++) cycle(ee, rr);
            if ($urandom_range(0, 19) == 0) reset_mid();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
